fcs_gen_tx: RTL and testbench

Ethernet FCS generator for the ARP transmit path. It sits upstream of the TX byte multiplexer. It accumulates a CRC-32 over every header and ARP payload byte as the multiplexer sends it. After the last payload byte it presents the 4 FCS bytes one per cycle on `fcs_tx_data`, and pulses `fcs_tx_done` on the final byte so the multiplexer can close the frame.

---
 rtl/eth_pkg.sv | 36 +++
 rtl/fcs_gen_tx_if.sv | 30 +++
 rtl/fcs_gen_tx.sv | 93 +++++++++
 tb/tb_fcs_gen_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet CRC-32 constants, FCS generator state type and byte-wise CRC update.
// Latency: none (package only).
// Backpressure: not applicable.
//
// Contents:
//   CRC32_POLY_REFL / CRC32_INIT / CRC32_RESIDUE : reflected IEEE 802.3 CRC-32 constants
//   crc32_byte(crc, data)                        : one byte of LSB-first CRC update
//   fcs_state_t                                  : FCS generator state encoding
package eth_pkg;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   // Register value left after a good frame plus its own FCS has been clocked through.
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SEND  = 2'd2
   } fcs_state_t;

   // Bitwise reflected CRC: data enters LSB first, one shift per bit.
   // Also intended for the RX FCS checker.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if ((c[0] ^ data[i]) == 1'b1)
            c = (c >> 1) ^ CRC32_POLY_REFL;
         else
            c = c >> 1;
      end
      return c;
   endfunction

endpackage

// File: rtl/fcs_gen_tx_if.sv
// Byte stream into the TX FCS generator and FCS bytes back out to the TX multiplexer.
// Latency: none (wires only).
// Backpressure: none; the consumer takes one FCS byte per cycle.
//
// Signals:
//   crc_init, crc_valid, crc_data[7:0], crc_last : frame byte stream (multiplexer side drives)
//   fcs_tx_data[7:0], fcs_tx_done, fcs_busy      : FCS output (generator drives)
interface fcs_gen_tx_if;

   logic       crc_init;
   logic       crc_valid;
   logic [7:0] crc_data;
   logic       crc_last;
   logic [7:0] fcs_tx_data;
   logic       fcs_tx_done;
   logic       fcs_busy;

   // Upstream / multiplexer side.
   modport master (
      output crc_init, crc_valid, crc_data, crc_last,
      input  fcs_tx_data, fcs_tx_done, fcs_busy
   );

   // FCS generator side.
   modport slave (
      input  crc_init, crc_valid, crc_data, crc_last,
      output fcs_tx_data, fcs_tx_done, fcs_busy
   );

endinterface

// File: rtl/fcs_gen_tx.sv
// Ethernet FCS generator: CRC-32 over transmitted header/payload bytes, then 4 FCS bytes.
// Latency: FCS bytes appear in cycles N+1..N+4 after the last byte is sampled at edge N.
// Backpressure: none; the consumer must accept one FCS byte per cycle.
//
// Ports:
//   aclk, areset : clock, asynchronous active-high reset
//   bus (slave)  : crc_init/crc_valid/crc_data/crc_last in; fcs_tx_data/fcs_tx_done/fcs_busy out
module fcs_gen_tx
   import eth_pkg::*;
(
   input  logic        aclk,
   input  logic        areset,
   fcs_gen_tx_if.slave bus
);

   fcs_state_t  r_state;
   fcs_state_t  w_state_nxt;
   logic [31:0] r_crc;
   logic [31:0] w_crc_nxt;
   logic [31:0] w_fcs;
   logic [1:0]  r_idx;
   logic [1:0]  w_idx_nxt;
   logic        r_busy;
   logic [7:0]  w_tx_data;
   logic        w_tx_done;

   always_comb begin
      w_state_nxt = r_state;
      w_crc_nxt   = r_crc;
      w_idx_nxt   = r_idx;
      w_tx_data   = 8'h00;
      w_tx_done   = 1'b0;
      w_fcs       = ~r_crc;

      case (r_state)
         IDLE: begin
            // Bytes outside a frame are not part of any CRC.
         end
         ACCUM: begin
            if (bus.crc_valid) begin
               w_crc_nxt = crc32_byte(r_crc, bus.crc_data);
               if (bus.crc_last) begin
                  w_state_nxt = SEND;
                  w_idx_nxt   = 2'd0;
               end
            end
         end
         SEND: begin
            // crc is frozen here; FCS goes out least significant byte first.
            w_tx_data = w_fcs[{r_idx, 3'b000} +: 8];
            w_tx_done = (r_idx == 2'd3);
            if (r_idx == 2'd3) begin
               w_state_nxt = IDLE;
               w_idx_nxt   = 2'd0;
            end else begin
               w_idx_nxt   = r_idx + 2'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_idx_nxt   = 2'd0;
         end
      endcase

      // A new frame start overrides everything, including a byte presented in
      // the same cycle; the aborted frame never signals completion.
      if (bus.crc_init) begin
         w_state_nxt = ACCUM;
         w_crc_nxt   = CRC32_INIT;
         w_idx_nxt   = 2'd0;
         w_tx_done   = 1'b0;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state <= IDLE;
         r_crc   <= CRC32_INIT;
         r_idx   <= 2'd0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_crc   <= w_crc_nxt;
         r_idx   <= w_idx_nxt;
         r_busy  <= (w_state_nxt != IDLE);
      end
   end

   assign bus.fcs_tx_data = w_tx_data;
   assign bus.fcs_tx_done = w_tx_done;
   assign bus.fcs_busy    = r_busy;

endmodule

// File: tb/tb_fcs_gen_tx.sv
module tb_fcs_gen_tx;

   logic aclk;
   logic areset;
   int   total;
   int   bad;
   logic [7:0] q[$];

   fcs_gen_tx_if bus ();

   fcs_gen_tx dut (
      .aclk   (aclk),
      .areset (areset),
      .bus    (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Reference CRC written in the "xor byte in, then 8 conditional shifts" form.
   function automatic logic [31:0] m_crc(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = (r >> 1) ^ (32'hEDB88320 & {32{r[0]}});
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.crc_init  = 1'b0;
      bus.crc_valid = 1'b0;
      bus.crc_data  = 8'h00;
      bus.crc_last  = 1'b0;
   endtask

   task automatic load_123456789();
      q.delete();
      for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
   endtask

   // Sends q as one frame (optionally with idle gaps) and checks the 4 FCS cycles.
   // The frame's crc_init is asserted in the current cycle.
   task automatic run_frame(input string tag, input bit gap, input bit has_exp,
                            input logic [31:0] exp_fcs);
      logic [31:0] res;
      res = 32'hFFFFFFFF;
      bus.crc_init = 1'b1;
      tick();
      bus.crc_init = 1'b0;
      check({tag, "_busy_accum"}, {31'd0, bus.fcs_busy}, 32'd1);
      for (int i = 0; i < q.size(); i++) begin
         if (gap && (i % 3 == 1)) begin
            bus.crc_valid = 1'b0;
            bus.crc_data  = 8'hA5;
            bus.crc_last  = 1'b0;
            tick();
         end
         bus.crc_valid = 1'b1;
         bus.crc_data  = q[i];
         bus.crc_last  = (i == q.size() - 1);
         res = m_crc(res, q[i]);
         tick();
      end
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         if (has_exp)
            check($sformatf("%s_fcs%0d", tag, k), {24'd0, bus.fcs_tx_data}, {24'd0, exp_fcs[8*k +: 8]});
         check($sformatf("%s_done%0d", tag, k), {31'd0, bus.fcs_tx_done}, {31'd0, (k == 3)});
         check($sformatf("%s_busy%0d", tag, k), {31'd0, bus.fcs_busy}, 32'd1);
         res = m_crc(res, bus.fcs_tx_data);
         tick();
      end
      check({tag, "_residue"}, res, 32'hDEBB20E3);
      check({tag, "_busy_end"}, {31'd0, bus.fcs_busy}, 32'd0);
      check({tag, "_done_end"}, {31'd0, bus.fcs_tx_done}, 32'd0);
      check({tag, "_data_end"}, {24'd0, bus.fcs_tx_data}, 32'd0);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      areset = 1'b1;
      idle_inputs();

      // Reset state.
      #12;
      check("rst_data", {24'd0, bus.fcs_tx_data}, 32'd0);
      check("rst_done", {31'd0, bus.fcs_tx_done}, 32'd0);
      check("rst_busy", {31'd0, bus.fcs_busy}, 32'd0);
      areset = 1'b0;
      tick();

      // Valid bytes in IDLE are ignored.
      bus.crc_valid = 1'b1;
      bus.crc_data  = 8'h55;
      bus.crc_last  = 1'b1;
      tick();
      tick();
      check("idle_ignore_busy", {31'd0, bus.fcs_busy}, 32'd0);
      check("idle_ignore_done", {31'd0, bus.fcs_tx_done}, 32'd0);
      idle_inputs();
      tick();

      // "123456789" -> CRC 0xCBF43926.
      load_123456789();
      run_frame("std", 1'b0, 1'b1, 32'hCBF43926);

      // Single zero byte -> CRC 0xD202EF8D.
      q.delete();
      q.push_back(8'h00);
      run_frame("one", 1'b0, 1'b1, 32'hD202EF8D);

      // Back-to-back: next init directly in cycle N+5.
      load_123456789();
      run_frame("b2b", 1'b0, 1'b1, 32'hCBF43926);

      // 60-byte ARP request frame with idle gaps; checked via residue.
      q.delete();
      for (int i = 0; i < 6; i++) q.push_back(8'hFF);
      q.push_back(8'h00); q.push_back(8'h11); q.push_back(8'h22);
      q.push_back(8'h33); q.push_back(8'h44); q.push_back(8'h55);
      q.push_back(8'h08); q.push_back(8'h06);
      q.push_back(8'h00); q.push_back(8'h01); q.push_back(8'h08); q.push_back(8'h00);
      q.push_back(8'h06); q.push_back(8'h04); q.push_back(8'h00); q.push_back(8'h01);
      q.push_back(8'h00); q.push_back(8'h11); q.push_back(8'h22);
      q.push_back(8'h33); q.push_back(8'h44); q.push_back(8'h55);
      q.push_back(8'hC0); q.push_back(8'hA8); q.push_back(8'h00); q.push_back(8'h01);
      for (int i = 0; i < 6; i++) q.push_back(8'h00);
      q.push_back(8'hC0); q.push_back(8'hA8); q.push_back(8'h00); q.push_back(8'h02);
      for (int i = 0; i < 18; i++) q.push_back(8'h00);
      run_frame("arp", 1'b1, 1'b0, 32'd0);

      // Abort in SEND after FCS byte 1 by pulsing crc_init.
      load_123456789();
      bus.crc_init = 1'b1;
      tick();
      bus.crc_init = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus.crc_valid = 1'b1;
         bus.crc_data  = q[i];
         bus.crc_last  = (i == 8);
         tick();
      end
      idle_inputs();
      check("abort_fcs0", {24'd0, bus.fcs_tx_data}, 32'h26);
      tick();
      check("abort_fcs1", {24'd0, bus.fcs_tx_data}, 32'h39);
      tick();
      bus.crc_init = 1'b1;
      #1;
      check("abort_done_init", {31'd0, bus.fcs_tx_done}, 32'd0);
      tick();
      bus.crc_init = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("abort_done_after%0d", i), {31'd0, bus.fcs_tx_done}, 32'd0);
         check($sformatf("abort_busy_after%0d", i), {31'd0, bus.fcs_busy}, 32'd1);
         tick();
      end
      load_123456789();
      run_frame("post_abort", 1'b0, 1'b1, 32'hCBF43926);

      // Init together with valid: byte dropped, so CRC still matches "123456789".
      load_123456789();
      bus.crc_valid = 1'b1;
      bus.crc_data  = 8'h77;
      run_frame("init_drop", 1'b0, 1'b1, 32'hCBF43926);

      // Asynchronous reset mid-ACCUM.
      bus.crc_init = 1'b1;
      tick();
      bus.crc_init = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.crc_valid = 1'b1;
         bus.crc_data  = 8'h31 + 8'(i);
         tick();
      end
      idle_inputs();
      check("pre_rst_busy", {31'd0, bus.fcs_busy}, 32'd1);
      #2;
      areset = 1'b1;
      #1;
      check("arst_busy", {31'd0, bus.fcs_busy}, 32'd0);
      check("arst_data", {24'd0, bus.fcs_tx_data}, 32'd0);
      check("arst_done", {31'd0, bus.fcs_tx_done}, 32'd0);
      #3;
      areset = 1'b0;
      tick();
      bus.crc_valid = 1'b1;
      bus.crc_data  = 8'h39;
      bus.crc_last  = 1'b1;
      tick();
      idle_inputs();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("post_rst_busy%0d", i), {31'd0, bus.fcs_busy}, 32'd0);
         check($sformatf("post_rst_done%0d", i), {31'd0, bus.fcs_tx_done}, 32'd0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the bench always ends by itself.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
